pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups, with one group per pipeline stage. The group carry is registered between stages, so any WIDTH runs at the clock rate of a single 4-bit CLA. It accepts one operation per cycle through a valid/ready handshake with backpressure. It is the arithmetic datapath block for wide-operand users, generalising the 4-bit CLA sum generator.

---
 rtl/pipelined_cla_adder.sv | 129 ++++++++++++
 tb/tb_pipelined_cla_adder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit CLA group per stage, group carry registered
// between stages, valid/ready handshake with full-pipeline stall. WIDTH must be a multiple of 4.
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  // Handshake: a beat moves on an edge where valid & ready. Producers hold their beat and data
  // until then; in_ready drops only while a result is presented and not taken.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = WIDTH / 4;

  logic             w_stall;
  logic [WIDTH-1:0] w_bx;
  logic             w_c0;
  logic             r_ovf;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_bx     = sub ? ~b : b;
  assign w_c0     = sub | cin;

  // Operand skew: stage k keeps only the groups that later stages still need, shifted down so
  // the next group to consume always sits in bits [3:0].
  for (genvar k = 0; k < NGRP - 1; k++) begin : g_skew
    localparam int RW = WIDTH - 4 * (k + 1);
    logic [RW-1:0] r_a;
    logic [RW-1:0] r_bx;
    logic [RW-1:0] w_a_nx;
    logic [RW-1:0] w_bx_nx;

    if (k == 0) begin : g_src
      assign w_a_nx  = a[WIDTH-1:4];
      assign w_bx_nx = w_bx[WIDTH-1:4];
    end else begin : g_src
      assign w_a_nx  = g_skew[k-1].r_a[RW+3:4];
      assign w_bx_nx = g_skew[k-1].r_bx[RW+3:4];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_a  <= '0;
        r_bx <= '0;
      end else if (!w_stall) begin
        r_a  <= w_a_nx;
        r_bx <= w_bx_nx;
      end
    end
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    logic [4*(k+1)-1:0] r_sum;
    logic               r_cy;
    logic               r_vld;
    logic [4*(k+1)-1:0] w_sum_nx;
    logic [3:0]         w_ga;
    logic [3:0]         w_gb;
    logic [3:0]         w_g;
    logic [3:0]         w_p;
    logic [4:0]         w_c;
    logic               w_ci;
    logic               w_vi;

    if (k == 0) begin : g_src
      assign w_ga     = a[3:0];
      assign w_gb     = w_bx[3:0];
      assign w_ci     = w_c0;
      assign w_vi     = in_valid;
      assign w_sum_nx = w_p ^ w_c[3:0];
    end else begin : g_src
      assign w_ga     = g_skew[k-1].r_a[3:0];
      assign w_gb     = g_skew[k-1].r_bx[3:0];
      assign w_ci     = g_stage[k-1].r_cy;
      assign w_vi     = g_stage[k-1].r_vld;
      assign w_sum_nx = {w_p ^ w_c[3:0], g_stage[k-1].r_sum};
    end

    assign w_g    = w_ga & w_gb;
    assign w_p    = w_ga ^ w_gb;
    assign w_c[0] = w_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & w_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_ci);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_ci);

    // Bubbles advance like data; the whole pipe freezes together on a stall.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sum <= '0;
        r_cy  <= 1'b0;
        r_vld <= 1'b0;
      end else if (!w_stall) begin
        r_sum <= w_sum_nx;
        r_cy  <= w_c[4];
        r_vld <= w_vi;
      end
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!w_stall) begin
      r_ovf <= g_stage[NGRP-1].w_c[3] ^ g_stage[NGRP-1].w_c[4];
    end
  end

  assign out_valid = g_stage[NGRP-1].r_vld;
  assign sum       = g_stage[NGRP-1].r_sum;
  assign cout      = g_stage[NGRP-1].r_cy;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: three instances (WIDTH 16/4/32) sharing one operand bus, directed
// vector table, backpressure and mid-stream reset sequences, and random streams scored against a model.
module tb_pipelined_cla_adder;

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          lat;
  } vec_t;

  localparam int EW = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_m, b_m;
  logic        cin_m, sub_m, iv_m, ordy_m;
  int          sel;

  logic        iv16, ir16, ov16, ordy16, co16, of16;
  logic        iv4,  ir4,  ov4,  ordy4,  co4,  of4;
  logic        iv32, ir32, ov32, ordy32, co32, of32;
  logic [15:0] s16;
  logic [3:0]  s4;
  logic [31:0] s32;
  logic        ir_m, ov_m, co_m, of_m;
  logic [31:0] sum_m;

  logic [EW-1:0] exp_q[$];
  vec_t          vecs[10];
  int            n_chk = 0, n_fail = 0, cyc = 0;
  int            t_first, t_last, n_out, n_stall;
  bit            mon_en = 1'b0;
  bit            done;

  // ---------------- clock / reset / routing ----------------
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign iv16   = iv_m && (sel == 0);
  assign iv4    = iv_m && (sel == 1);
  assign iv32   = iv_m && (sel == 2);
  assign ordy16 = (sel == 0) ? ordy_m : 1'b1;
  assign ordy4  = (sel == 1) ? ordy_m : 1'b1;
  assign ordy32 = (sel == 2) ? ordy_m : 1'b1;

  always_comb begin
    ir_m = ir16; ov_m = ov16; co_m = co16; of_m = of16; sum_m = {16'd0, s16};
    if (sel == 1) begin
      ir_m = ir4; ov_m = ov4; co_m = co4; of_m = of4; sum_m = {28'd0, s4};
    end else if (sel == 2) begin
      ir_m = ir32; ov_m = ov32; co_m = co32; of_m = of32; sum_m = s32;
    end
  end

  pipelined_cla_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a_m[15:0]), .b(b_m[15:0]),
    .cin(cin_m), .sub(sub_m), .out_valid(ov16), .out_ready(ordy16), .sum(s16), .cout(co16), .ovf(of16));
  pipelined_cla_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a_m[3:0]), .b(b_m[3:0]),
    .cin(cin_m), .sub(sub_m), .out_valid(ov4), .out_ready(ordy4), .sum(s4), .cout(co4), .ovf(of4));
  pipelined_cla_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a_m), .b(b_m),
    .cin(cin_m), .sub(sub_m), .out_valid(ov32), .out_ready(ordy32), .sum(s32), .cout(co32), .ovf(of32));

  // ---------------- reference model and helpers ----------------
  function automatic int wd(input int d);
    return (d == 0) ? 16 : (d == 1) ? 4 : 32;
  endfunction

  // Plain integer arithmetic: sum modulo 2^w, carry is bit w, overflow from operand/result signs.
  function automatic logic [EW-1:0] model(input int w, input logic [31:0] a, b, input logic c, s);
    logic [63:0] mask, av, bv, t;
    logic co, ov, sa, sb, ss;
    mask = (64'd1 << w) - 64'd1;
    av   = {32'd0, a} & mask;
    bv   = {32'd0, (s ? ~b : b)} & mask;
    t    = av + bv + (s ? 64'd1 : {63'd0, c});
    co   = t[w];
    sa   = av[w-1];
    sb   = bv[w-1];
    ss   = t[w-1];
    ov   = (sa == sb) && (ss != sa);
    return {ov, co, t[31:0] & mask[31:0]};
  endfunction

  function automatic vec_t mk(input int d, input logic [31:0] a, b, input logic cin, sub,
                              input logic [31:0] s, input logic co, ov, input int lat);
    vec_t v;
    v.d = d; v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.s = s; v.co = co; v.ov = ov; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; holds the beat until in_ready is seen before an edge.
  task automatic put_beat(input logic [31:0] a, b, input logic c, s);
    bit acc;
    int guard;
    acc = 1'b0; guard = 0;
    a_m = a; b_m = b; cin_m = c; sub_m = s; iv_m = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = ir_m;
      guard++;
    end
    check("beat_accepted", acc, 1'b1);
    if (acc) begin
      if (mon_en) exp_q.push_back(model(wd(sel), a, b, c, s));
      if (t_first < 0) t_first = cyc;
    end
    @(posedge clk); #1;
    iv_m = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit seen;
    sel = v.d; ordy_m = 1'b1;
    @(posedge clk); #1;
    a_m = v.a; b_m = v.b; cin_m = v.cin; sub_m = v.sub; iv_m = 1'b1;
    @(negedge clk);
    check("vec_in_ready", ir_m, 1'b1);
    @(posedge clk); #1;
    iv_m = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      seen = ov_m;
    end
    check("vec_latency", lat, v.lat);
    check("vec_sum", sum_m, v.s);
    check("vec_cout", co_m, v.co);
    check("vec_ovf", of_m, v.ov);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      2:       return 32'h7FFF_FFFF >> (4 * $urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_run(input int d, input int n);
    int g;
    logic [31:0] ra, rb;
    sel = d; mon_en = 1'b1; done = 1'b0; t_first = -1; ordy_m = 1'b1;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          ra = pick(); rb = pick();
          put_beat(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ordy_m = ($urandom_range(0, 9) < 7);
        end
        ordy_m = 1'b1;
      end
    join
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("rand_drain", exp_q.size(), 0);
    mon_en = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("in_ready_vs_stall", ir_m, !(ov_m && !ordy_m));
      if (ov_m) begin
        if (!ordy_m) n_stall++;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", ov_m, 1'b0);
        end else begin
          check(ordy_m ? "rsp_retire" : "rsp_hold", {of_m, co_m, sum_m}, exp_q[0]);
          if (ordy_m) begin
            void'(exp_q.pop_front());
            n_out++;
            t_last = cyc;
          end
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int g, stale;
    rst = 1'b1; iv_m = 1'b0; ordy_m = 1'b1; a_m = '0; b_m = '0; cin_m = 1'b0; sub_m = 1'b0; sel = 0;
    t_first = -1; t_last = 0; n_out = 0; n_stall = 0;

    vecs[0] = mk(0, 32'h0005, 32'h0003, 1'b0, 1'b0, 32'h0008, 1'b0, 1'b0, 4);
    vecs[1] = mk(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, 4);
    vecs[2] = mk(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 4);
    vecs[3] = mk(0, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0, 32'hFFFF, 1'b1, 1'b0, 4);
    vecs[4] = mk(0, 32'h0003, 32'h0005, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0, 4);
    vecs[5] = mk(0, 32'h8000, 32'h0001, 1'b1, 1'b1, 32'h7FFF, 1'b1, 1'b1, 4);
    vecs[6] = mk(0, 32'h1234, 32'h1234, 1'b0, 1'b1, 32'h0000, 1'b1, 1'b0, 4);
    vecs[7] = mk(1, 32'hF, 32'hF, 1'b1, 1'b0, 32'hF, 1'b1, 1'b0, 1);
    vecs[8] = mk(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8);
    vecs[9] = mk(2, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 8);

    // Reset values on all three widths.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ov16", ov16, 1'b0); check("rst_s16", s16, 16'h0);
    check("rst_co16", co16, 1'b0); check("rst_of16", of16, 1'b0);
    check("rst_ov4", ov4, 1'b0);   check("rst_s4", s4, 4'h0);
    check("rst_co4", co4, 1'b0);   check("rst_of4", of4, 1'b0);
    check("rst_ov32", ov32, 1'b0); check("rst_s32", s32, 32'h0);
    check("rst_co32", co32, 1'b0); check("rst_of32", of32, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ir16", ir16, 1'b1);
    check("post_rst_ir4", ir4, 1'b1);
    check("post_rst_ir32", ir32, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: 8 back-to-back beats, 3-cycle out_ready drop at the first result.
    sel = 0; ordy_m = 1'b1; exp_q.delete(); t_first = -1; n_out = 0; n_stall = 0; mon_en = 1'b1;
    fork
      begin
        for (int n = 1; n <= 8; n++) put_beat(n, 32'h1000, 1'b0, 1'b0);
      end
      begin
        g = 0;
        do begin
          @(posedge clk); #1;
          g++;
        end while (!ov_m && g < 50);
        ordy_m = 1'b0;
        repeat (3) @(posedge clk);
        #1 ordy_m = 1'b1;
      end
    join
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("bp_results", n_out, 8);
    check("bp_stall_cycles", n_stall, 3);
    check("bp_total_cycles", t_last - t_first, 14);
    mon_en = 1'b0;
    @(posedge clk); #1;

    // Reset with three beats in flight.
    sel = 0; ordy_m = 1'b1;
    for (int n = 0; n < 3; n++) put_beat(32'h0100 + n, 32'h0011, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", ov_m, 1'b0);
    check("midrst_sum", sum_m, 32'h0);
    check("midrst_cout", co_m, 1'b0);
    check("midrst_ovf", of_m, 1'b0);
    check("midrst_in_ready", ir_m, 1'b1);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov_m) stale++;
    end
    check("midrst_no_stale", stale, 0);
    exp_q.delete();
    @(posedge clk); #1;
    run_vec(vecs[2]);

    rand_run(0, 60);
    rand_run(1, 60);
    rand_run(2, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
